aes_decipher_engine: RTL

AES_DECIPHER_ENGINE -- requirements
Module: aes_decipher_engine

---
 rtl/aes_decipher_engine.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_decipher_engine.sv
// Iterative AES inverse cipher: one AddRoundKey/InvMixColumns/InvShiftRows step per round,
// with InvSubBytes spread over 4/NUM_SBOX cycles of NUM_SBOX word substitutions each.
module aes_decipher_engine #(
   parameter int unsigned NUM_SBOX = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         abort,
   input  logic [1:0]   keylen,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   input  logic [127:0] block,
   output logic [127:0] new_block,
   output logic         ready,
   output logic         result_valid
);

   localparam int unsigned BLK_W = 128;
   localparam int unsigned RND_W = 4;
   localparam int unsigned CTR_W = 2;
   localparam int unsigned KL_W  = 2;
   localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(4 - NUM_SBOX);

   if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
      $error("aes_decipher_engine: NUM_SBOX must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

   localparam logic [0:255][7:0] INV_SBOX = {
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant k in GF(2^8) mod 0x11B.
   function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x1, x2, x3;
      x1 = xtime(b);
      x2 = xtime(x1);
      x3 = xtime(x2);
      return (k[0] ? b : 8'h00) ^ (k[1] ? x1 : 8'h00) ^ (k[2] ? x2 : 8'h00) ^ (k[3] ? x3 : 8'h00);
   endfunction

   function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
      return {INV_SBOX[w[31:24]], INV_SBOX[w[23:16]], INV_SBOX[w[15:8]], INV_SBOX[w[7:0]]};
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
              gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
              gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
              gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
   endfunction

   function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
      return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
              inv_mix_column(s[63:32]), inv_mix_column(s[31:0])};
   endfunction

   // Row r of the column-major state rotates right by r byte positions.
   function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
      logic [0:15][7:0] b;
      b = s;
      return {b[0],  b[13], b[10], b[7],
              b[4],  b[1],  b[14], b[11],
              b[8],  b[5],  b[2],  b[15],
              b[12], b[9],  b[6],  b[3]};
   endfunction

   function automatic logic [RND_W-1:0] num_rounds(input logic [KL_W-1:0] kl);
      case (kl)
         2'd1:    return RND_W'(12);
         2'd2:    return RND_W'(14);
         default: return RND_W'(10);
      endcase
   endfunction

   state_t              state_q, state_d;
   logic [RND_W-1:0]    round_q, round_d;
   logic [BLK_W-1:0]    new_block_q, new_block_d;
   logic                ready_q, ready_d;
   logic                result_valid_q, result_valid_d;
   logic [CTR_W-1:0]    sword_ctr_q, sword_ctr_d;
   logic [KL_W-1:0]     keylen_q, keylen_d;

   logic [3:0][31:0]              st_w, sbox_w;
   logic [NUM_SBOX-1:0][CTR_W-1:0] word_idx;
   logic [BLK_W-1:0]              init_blk, main_blk, final_blk;

   // Word k of the state sits at packed index 3-k, i.e. the bitwise inverse of a 2-bit k.
   assign st_w = new_block_q;

   always_comb begin
      sbox_w   = st_w;
      word_idx = '0;
      for (int j = 0; j < NUM_SBOX; j++) begin
         word_idx[j]          = sword_ctr_q + CTR_W'(j);
         sbox_w[~word_idx[j]] = inv_sub_word(st_w[~word_idx[j]]);
      end
   end

   assign init_blk  = inv_shift_rows(block ^ round_key);
   assign main_blk  = inv_shift_rows(inv_mix_columns(new_block_q ^ round_key));
   assign final_blk = new_block_q ^ round_key;

   always_comb begin
      state_d        = state_q;
      round_d        = round_q;
      new_block_d    = new_block_q;
      ready_d        = ready_q;
      result_valid_d = 1'b0;
      sword_ctr_d    = sword_ctr_q;
      keylen_d       = keylen_q;
      if (abort && state_q != IDLE) begin
         state_d     = IDLE;
         round_d     = '0;
         ready_d     = 1'b1;
         sword_ctr_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !abort) begin
                  keylen_d = keylen;
                  round_d  = num_rounds(keylen);
                  ready_d  = 1'b0;
                  state_d  = INIT;
               end
            end
            INIT: begin
               new_block_d = init_blk;
               sword_ctr_d = '0;
               state_d     = SBOX;
            end
            SBOX: begin
               new_block_d = sbox_w;
               sword_ctr_d = sword_ctr_q + CTR_W'(NUM_SBOX);
               if (sword_ctr_q == LAST_CTR) begin
                  round_d = round_q - RND_W'(1);
                  state_d = MAIN;
               end
            end
            MAIN: begin
               if (round_q != '0) begin
                  new_block_d = main_blk;
                  state_d     = SBOX;
               end else begin
                  new_block_d    = final_blk;
                  ready_d        = 1'b1;
                  result_valid_d = 1'b1;
                  state_d        = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         round_q        <= '0;
         new_block_q    <= '0;
         ready_q        <= 1'b1;
         result_valid_q <= 1'b0;
         sword_ctr_q    <= '0;
         keylen_q       <= '0;
      end else begin
         state_q        <= state_d;
         round_q        <= round_d;
         new_block_q    <= new_block_d;
         ready_q        <= ready_d;
         result_valid_q <= result_valid_d;
         sword_ctr_q    <= sword_ctr_d;
         keylen_q       <= keylen_d;
      end
   end

   assign round        = round_q;
   assign new_block    = new_block_q;
   assign ready        = ready_q;
   assign result_valid = result_valid_q;

endmodule
